// File: rtl/frequency_generator.sv
`default_nettype none
// ============================================================================
//  Module   : frequency_generator
//  Purpose  : Integer clock divider. Produces OutputCLK at
//             inputFrequency / (inputFrequency / frequency) Hz from InputCLK.
//             The divide ratio N = inputFrequency / frequency (truncated).
//             Each period is low for L = floor(N/2) cycles and high for
//             N - L cycles, so an odd N gives the extra cycle to the high phase.
//  Ports    : InputCLK  (in)  sole clock, rising-edge active
//             Reset     (in)  asynchronous, active-high reset
//             OutputCLK (out) divided clock, driven straight from a flop
//  Revision : 1.0  initial release
// ============================================================================
module frequency_generator #(
    parameter int unsigned inputFrequency = 50000000,
    parameter int unsigned frequency      = 50,
    parameter int unsigned bitsNumber     = 21
) (
    input  logic InputCLK,
    input  logic Reset,
    output logic OutputCLK
);

    // Divide ratio and low-phase length, derived at elaboration time.
    localparam longint unsigned N = longint'(inputFrequency / frequency);
    localparam longint unsigned L = N / 2;

    // Counter capacity, computed wide so bitsNumber up to 63 is safe.
    localparam longint unsigned C_CAPACITY = 64'd1 << bitsNumber;

    // bitsNumber-wide constants used by the wrap and the phase compare.
    localparam logic [bitsNumber-1:0] C_LAST = bitsNumber'(N - 1);
    localparam logic [bitsNumber-1:0] C_LOW  = bitsNumber'(L);
    localparam logic [bitsNumber-1:0] C_ZERO = '0;
    localparam logic [bitsNumber-1:0] C_ONE  = bitsNumber'(1);

    // Elaboration guards: a ratio below 2 cannot form two phases, and the
    // counter must be able to hold N-1.
    if (N < 2) begin : g_bad_ratio
        $fatal(1, "frequency_generator: divide ratio N must be at least 2");
    end

    if (C_CAPACITY < N) begin : g_bad_width
        $fatal(1, "frequency_generator: bitsNumber too small to hold N-1");
    end

    logic [bitsNumber-1:0] counter_q;
    logic [bitsNumber-1:0] counter_d;
    logic                  out_q;
    logic                  out_d;

    // Next counter value: wrap to zero after N-1.
    always_comb begin
        counter_d = counter_q + C_ONE;
        if (counter_q == C_LAST) begin
            counter_d = C_ZERO;
        end
    end

    // The output flop is loaded from the next counter value so that it
    // reflects the phase of the count it is registered alongside. This keeps
    // OutputCLK free of decode glitches, as it feeds downstream clock pins.
    always_comb begin
        out_d = (counter_d >= C_LOW);
    end

    always_ff @(posedge InputCLK or posedge Reset) begin
        if (Reset) begin
            counter_q <= C_ZERO;
            out_q     <= 1'b0;
        end else begin
            counter_q <= counter_d;
            out_q     <= out_d;
        end
    end

    assign OutputCLK = out_q;

endmodule
`default_nettype wire

// File: tb/tb_frequency_generator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_frequency_generator
//  Purpose  : Self-checking bench for frequency_generator. Two instances are
//             exercised from one clock and reset: N=10/L=5 and N=5/L=2.
//             Expected output is derived from the number of rising edges seen
//             since reset release: high when (edges mod N) >= L.
//  Revision : 1.0  initial release
// ============================================================================
module tb_frequency_generator;

    logic clk;
    logic rst;
    logic out_a;
    logic out_b;

    int checks;
    int errors;
    int ecount;          // rising edges since the last reset release
    time last_clk_t;
    time last_rst_t;

    frequency_generator #(
        .inputFrequency (10),
        .frequency      (1),
        .bitsNumber     (4)
    ) dut_a (
        .InputCLK  (clk),
        .Reset     (rst),
        .OutputCLK (out_a)
    );

    frequency_generator #(
        .inputFrequency (15),
        .frequency      (3),
        .bitsNumber     (3)
    ) dut_b (
        .InputCLK  (clk),
        .Reset     (rst),
        .OutputCLK (out_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at t=%0t: got %b, expected %b", name, $time, act, exp);
        end
    endfunction

    // Reference: after k edges since release, output is ((k mod N) >= L).
    function automatic logic model(input int k, input int n, input int l);
        return ((k % n) >= l);
    endfunction

    always @(posedge clk) begin
        last_clk_t = $time;
        if (!rst) ecount++;
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if ($time > 20) begin
            check("cycle_a", out_a, rst ? 1'b0 : model(ecount, 10, 5));
            check("cycle_b", out_b, rst ? 1'b0 : model(ecount, 5, 2));
        end
    end

    // Output may only move together with a clock edge or reset assertion.
    always @(out_a) begin
        if ($time > 0 && $time != last_clk_t && $time != last_rst_t) begin
            checks++;
            errors++;
            $display("FAIL glitch_a at t=%0t: changed to %b off edge", $time, out_a);
        end
    end

    always @(out_b) begin
        if ($time > 0 && $time != last_clk_t && $time != last_rst_t) begin
            checks++;
            errors++;
            $display("FAIL glitch_b at t=%0t: changed to %b off edge", $time, out_b);
        end
    end

    task automatic assert_reset();
        rst        = 1'b1;
        last_rst_t = $time;
        ecount     = 0;
    endtask

    initial begin
        int hold;
        checks     = 0;
        errors     = 0;
        ecount     = 0;
        last_clk_t = 0;
        last_rst_t = 0;
        hold       = 0;
        rst        = 1'b1;

        repeat (3) @(negedge clk);
        check("reset_a", out_a, 1'b0);
        check("reset_b", out_b, 1'b0);
        #2 rst = 1'b0;

        // Hand-computed pins of the first periods after release.
        for (int k = 1; k <= 17; k++) begin
            @(posedge clk);
            #1;
            case (k)
                1:  check("pin_b_e1",  out_b, 1'b0);
                2:  check("pin_b_e2",  out_b, 1'b1);
                4:  begin check("pin_a_e4", out_a, 1'b0); check("pin_b_e4", out_b, 1'b1); end
                5:  begin check("pin_a_e5", out_a, 1'b1); check("pin_b_e5", out_b, 1'b0); end
                7:  check("pin_b_e7",  out_b, 1'b1);
                9:  check("pin_a_e9",  out_a, 1'b1);
                10: check("pin_a_e10", out_a, 1'b0);
                15: check("pin_a_e15", out_a, 1'b1);
                17: check("pin_a_cnt7", out_a, 1'b1);
                default: ;
            endcase
        end

        // Mid-period reset with no clock edge: output must drop at once.
        @(negedge clk);
        #2 assert_reset();
        #1;
        check("async_rst_a", out_a, 1'b0);
        check("async_rst_b", out_b, 1'b0);
        @(negedge clk);
        #2 rst = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            #1;
            if (k == 4) check("restart_a_e4", out_a, 1'b0);
            if (k == 5) check("restart_a_e5", out_a, 1'b1);
        end

        // Randomized reset pulses; the per-cycle compare does the checking.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            #2;
            if (rst) begin
                hold--;
                if (hold <= 0) rst = 1'b0;
            end else if ($urandom_range(0, 99) < 2) begin
                assert_reset();
                hold = int'($urandom_range(1, 4));
                #1;
                check("rand_rst_a", out_a, 1'b0);
                check("rand_rst_b", out_b, 1'b0);
            end
        end

        rst = 1'b0;
        repeat (25) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/frequency_generator.md
FREQUENCY_GENERATOR -- requirements
Module: frequency_generator

Interface
REQ-001 Parameter inputFrequency, default 50000000, input clock frequency in Hz.
REQ-002 Parameter frequency, default 50, required output clock frequency in Hz.
REQ-003 Parameter bitsNumber, default 21, divider counter width in bits.
REQ-004 Port InputCLK  input  1  sole clock; all state updates on its rising edge.
REQ-005 Port Reset  input  1  asynchronous, active-high reset.
REQ-006 Port OutputCLK  output  1  divided clock, registered, glitch-free.
REQ-007 The block SHALL have one clock (InputCLK) and an asynchronous active-high reset (Reset); no other ports.

Function
REQ-008 Divide ratio N SHALL be inputFrequency / frequency, using integer division with truncation.
REQ-009 Low-phase length L SHALL be floor(N/2) InputCLK cycles; high-phase length H SHALL be N - L cycles (odd N gives the extra cycle to high).
REQ-010 Counter SHALL be bitsNumber bits wide and SHALL count 0..N-1 on each InputCLK rising edge.
REQ-011 After N-1, the counter SHALL wrap to 0 on the next edge; no other terminal behaviour.
REQ-012 OutputCLK SHALL be a flip-flop output loaded each edge with (next counter value >= L).
REQ-013 OutputCLK SHALL therefore be 0 for counter values 0..L-1 and 1 for L..N-1.
REQ-014 Latency from reset release: first OutputCLK rising edge SHALL occur on the L-th InputCLK rising edge.
REQ-015 Subsequent OutputCLK rising edges SHALL be exactly N InputCLK cycles apart; falling edges SHALL occur on counter wrap.
REQ-016 OutputCLK SHALL never be driven from combinational logic (no decode glitches); it is used as a clock by downstream logic.
REQ-017 Default parameters: N = 1000000, L = H = 500000, OutputCLK = 50 Hz, 50 % duty.
REQ-018 Elaboration SHALL fail (fatal/assertion) if N < 2.
REQ-019 Elaboration SHALL fail if 2**bitsNumber < N, i.e. the counter cannot hold N-1.
REQ-020 Counter arithmetic SHALL be unsigned; compare and wrap SHALL use bitsNumber-wide constants derived from N and L.

Reset
REQ-021 Reset asserted SHALL immediately (asynchronously) force counter = 0 and OutputCLK = 0.
REQ-022 While Reset is high, state SHALL hold at 0 regardless of InputCLK.
REQ-023 Reset asserted mid-period SHALL abort the current phase; after deassertion, timing SHALL restart per REQ-014.
REQ-024 Reset deassertion is synchronised externally; no internal reset synchroniser is required.

Structure
REQ-025 N and L SHALL be localparams computed inside the module.
REQ-026 No shared package is required: no typedefs, and no constants are reused by other blocks.
REQ-027 The block SHALL be a single module with no sub-modules: one counter register and one output register.

Verification
REQ-028 inputFrequency=10, frequency=1 (N=10, L=5): release Reset -> OutputCLK 0 for 5 edges, 1 for 5 edges, repeating with period 10.
REQ-029 inputFrequency=15, frequency=3 (N=5, L=2): OutputCLK low 2 cycles, high 3 cycles, period 5.
REQ-030 inputFrequency=10, frequency=1: assert Reset at counter=7 with no clock edge -> OutputCLK drops to 0 immediately; after release, first rise on 5th edge.
REQ-031 Defaults (N=1000000): first rise on edge 500000, next rise on edge 1500000.
REQ-032 Default parameters with bitsNumber=19 -> elaboration error; with inputFrequency=1, frequency=1 -> elaboration error.
REQ-033 Across every scenario: OutputCLK SHALL change only coincident with InputCLK rising edges or Reset assertion (checked by assertion).
